// File: rtl/furv_pkg.sv
// Shared types and constants for the M-extension multiply/divide unit.
package furv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Most-negative two's complement value of a w-bit word (w <= 64).
    function automatic logic [63:0] most_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
//
// state | meaning
// IDLE  | waiting for a request, in_ready = 1
// CALC  | one multiply/divide iteration per cycle, cnt = 0..WIDTH-1
// DONE  | result held in out with out_valid = 1 until out_ready
module md_unit
    import furv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(most_neg(WIDTH));
    localparam logic [CW-1:0]    LAST_IT = CW'(WIDTH - 1);

    md_state_e          state;
    md_op_e             op_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mag_op;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    md_op_e             op_in;
    logic               a_sgn, b_sgn, a_neg, b_neg, is_div, is_rem;
    logic [WIDTH-1:0]   a_mag, b_mag, short_res;
    logic               div_zero, div_ovf;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, result;

    assign in_ready = (state == IDLE);

    always_comb begin
        op_in    = md_op_e'(op);
        a_sgn    = (op_in == MD_MULH) || (op_in == MD_MULHSU) ||
                   (op_in == MD_DIV)  || (op_in == MD_REM);
        b_sgn    = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
        a_neg    = a_sgn && ra[WIDTH-1];
        b_neg    = b_sgn && rb[WIDTH-1];
        a_mag    = a_neg ? -ra : ra;
        b_mag    = b_neg ? -rb : rb;
        is_div   = op[2];
        is_rem   = op[2] && op[1];
        div_zero = is_div && (rb == '0);
        div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                   (ra == MIN_VAL) && (rb == '1);
        if (div_zero)
            short_res = is_rem ? ra : '1;
        else
            short_res = is_rem ? '0 : ra;
    end

    // Multiply keeps the partial product in the upper half and the multiplier
    // in the lower half; divide keeps the partial remainder above the
    // dividend bits, which are replaced by quotient bits as they shift out.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_op} : '0);
        mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, mag_op};
        if (diff[WIDTH])
            div_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        acc_nxt  = op_q[2] ? div_nxt : mul_nxt;
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        q_fix    = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
        r_fix    = neg_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
        case (op_q)
            MD_MUL:          result = prod_fix[WIDTH-1:0];
            MD_DIV, MD_DIVU: result = q_fix;
            MD_REM, MD_REMU: result = r_fix;
            default:         result = prod_fix[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= MD_MUL;
            neg_q     <= 1'b0;
            mag_op    <= '0;
            acc       <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= op_in;
                        neg_q  <= is_rem ? a_neg : (a_neg ^ b_neg);
                        mag_op <= is_div ? b_mag : a_mag;
                        acc    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        cnt    <= '0;
                        if (div_zero || div_ovf) begin
                            out       <= short_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IT) begin
                        out       <= result;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit at WIDTH=32 against an arithmetic reference model.
module tb_md_unit;

    localparam int W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  ra = '0;
    logic [W-1:0]  rb = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out;

    int checks = 0;
    int failures = 0;

    md_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .ra        (ra),
        .rb        (rb),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_md(input int o, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ubv = {32'b0, b};
        case (o)
            0: begin p = ua * ubv; return p[31:0]; end
            1: begin p = 64'(sa * sb); return p[63:32]; end
            2: begin p = 64'(sa * ub); return p[63:32]; end
            3: begin p = ua * ubv; return p[63:32]; end
            4: begin
                if (b == 0) return '1;
                if (a == MINV && b == '1) return a;
                return 32'(sa / sb);
            end
            5: return (b == 0) ? '1 : a / b;
            6: begin
                if (b == 0) return a;
                if (a == MINV && b == '1) return '0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input int o, input logic [31:0] a, input logic [31:0] b);
        if (o >= 4 && b == 0) return 1;
        if ((o == 4 || o == 6) && a == MINV && b == '1) return 1;
        return W + 1;
    endfunction

    // Entered at #1 after a rising edge in IDLE (that edge is edge 0); leaves
    // at #1 after the edge that completes the result handshake.
    task automatic run_op(input string tag, input int o, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat = 0;
        bit          busy_ok = 1'b1;
        bit          hold_ok = 1'b1;
        logic [31:0] exp_r = ref_md(o, a, b);
        logic [31:0] seen;
        out_ready = (hold == 0);
        op = 3'(o); ra = a; rb = b; in_valid = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (e == 1) in_valid = 1'b0;
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            if (out_valid === 1'b1) begin lat = e; break; end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(ref_lat(o, a, b)));
        chk({tag, "_out"}, {32'b0, out}, {32'b0, exp_r});
        chk({tag, "_busy"}, {63'b0, busy_ok}, 64'd1);
        seen = out;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (out !== seen || out_valid !== 1'b1 || in_ready !== 1'b0) hold_ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold"}, {63'b0, hold_ok}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_idle_rdy"}, {63'b0, in_ready}, 64'd1);
        chk({tag, "_idle_vld"}, {63'b0, out_valid}, 64'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return MINV;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen_vld;
        #2;
        chk("reset_rdy", {63'b0, in_ready}, 64'd1);
        chk("reset_vld", {63'b0, out_valid}, 64'd0);
        chk("reset_out", {32'b0, out}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul", 0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("mulh", 1, MINV, MINV, 0);
        run_op("mulhu", 3, '1, '1, 0);
        run_op("mulhsu", 2, '1, '1, 0);
        run_op("div", 4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem", 6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu", 5, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("remu", 7, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_z", 5, 32'd5, 32'd0, 0);
        run_op("remu_z", 7, 32'd5, 32'd0, 0);
        run_op("div_ovf", 4, MINV, '1, 0);
        run_op("rem_ovf", 6, MINV, '1, 0);
        run_op("backpr", 0, 32'd1234, 32'd5678, 5);
        run_op("b2b", 1, 32'hDEAD_BEEF, 32'h1234_5678, 0);

        // Flush while idle with a pending request: nothing is accepted.
        in_valid = 1'b1; flush = 1'b1; op = 3'd0; ra = 32'd3; rb = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_rdy", {63'b0, in_ready}, 64'd1);
        chk("idle_flush_vld", {63'b0, out_valid}, 64'd0);

        // Flush at iteration 10.
        op = 3'd0; ra = 32'd9; rb = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_rdy", {63'b0, in_ready}, 64'd1);
        chk("flush_vld", {63'b0, out_valid}, 64'd0);
        seen_vld = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen_vld = 1'b1;
        end
        chk("flush_no_result", {63'b0, seen_vld}, 64'd0);

        // Asynchronous reset at iteration 20.
        op = 3'd4; ra = 32'd1000; rb = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_vld", {63'b0, out_valid}, 64'd0);
        chk("arst_rdy", {63'b0, in_ready}, 64'd1);
        chk("arst_out", {32'b0, out}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 0, 32'd3, 32'd4, 0);

        for (int i = 0; i < 40; i++) begin
            int          o;
            logic [31:0] a, b;
            o = int'($urandom_range(0, 7));
            a = pick_val();
            b = pick_val();
            run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
